ahb_refill_master: RTL and testbench
====================================

Name: ahb_refill_master

Overview:
- AHB-Lite initiator for I-cache line refill; the requesting end of the bus whose responder side tracks SINGLE/WRAP4 transfers.
- Takes one miss request (critical word address) from the cache controller and issues one 4-beat WRAP4 read burst, critical word first.
- Handles wait states and error responses, and returns the assembled 128-bit line to the cache.

Parameters:
- WRAP4_BOUNDARY_MASK, 32'hFFFF_FFF0, line-base mask for a 16-byte wrap boundary.
- HPROT_VAL, 4'b0010, constant HPROT: privileged opcode fetch.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  refill request.
- req_addr  in  32  miss address; bits[1:0] are ignored (forced to 0).
- req_ready  out  1  high only in IDLE.
- haddr  out  32  AHB address.
- htrans  out  2  AHB transfer type (IDLE/NONSEQ/SEQ).
- hburst  out  3  constant WRAP4 (3'b010).
- hsize  out  3  constant 3'b010 (word).
- hwrite  out  1  constant 0.
- hprot  out  4  HPROT_VAL.
- hrdata  in  32  read data.
- hready  in  1  transfer done / wait state.
- hresp  in  1  0=OKAY, 1=ERROR.
- line_done  out  1  one-cycle pulse when the burst ends.
- line_err  out  1  valid with line_done; 1 = ERROR seen.
- line_data  out  128  word i placed at bits [32i+31:32i], i = beat_addr[3:2].
- line_addr  out  32  line base address, valid with line_done.

Behaviour:
- All outputs are registered.
- Reset values:
  - htrans=IDLE, haddr=0, req_ready=1.
  - line_done=0, line_err=0, line_data=0, line_addr=0.
  - All counters 0.
- Reset mid-burst: next edge goes to IDLE with htrans=IDLE. No line_done. Captured data is discarded.
- States: IDLE, ADDR, LAST, ERR, DONE.
- IDLE:
  - On req_valid, latch base = req_addr & mask and off = req_addr[3:2].
  - Next cycle: ADDR, htrans=NONSEQ, haddr=req_addr & ~3.
  - req_valid in any other state is ignored.
- Address counter a_cnt[1:0] and data counter d_cnt[1:0]:
  - Beat n address = base | ((off+n) mod 4)<<2.
  - Wrap arithmetic is 2-bit, so it rolls over without carry into bit 4.
- ADDR, on hready=1:
  - The pending data phase (if any) completes.
  - The address advances: a_cnt+1, htrans=SEQ.
  - After beat 3's address is accepted: htrans=IDLE, go to LAST.
- ADDR, on hready=0: haddr, htrans and counters hold.
- Data capture: on hready=1 && hresp=0 with a data phase outstanding, store hrdata into the word at that beat's [3:2] index, then d_cnt+1.
- LAST: on hready=1 && hresp=0, capture beat 3 and go to DONE.
- ERROR response (first cycle hresp=1, hready=0), from ADDR or LAST:
  - Next cycle htrans=IDLE (burst cancelled); go to ERR.
  - ERR waits for hready=1, then goes to DONE with line_err=1.
- DONE: one cycle; line_done=1, line_addr=base. Then IDLE; req_ready returns the following cycle.
- Latency, zero wait states: request accepted at cycle T, NONSEQ at T+1, last data at T+5, line_done at T+6.
- hready is never sampled in IDLE or DONE.

Optional Feature:
- REFILL_EARLY_RESTART_EN defined: adds ports word_valid (out 1), word_data (out 32) and word_idx (out 2).
  - word_valid pulses the cycle after each beat capture, first beat = critical word.
  - Lets the fetch stage restart before line_done.
- Not defined: the ports are absent; only line_done reports data.

Decomposition:
- interface_pkg:
  - BURST_TYPES (SINGLE=0, INCR=1, WRAP4=2) and TRANS_TYPES (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), both shared with the responder side.
  - REFILL_STATES enum.
  - WRAP4_BEATS=4 constant.
- One sub-module, refill_line_buffer: 4x32 word register with indexed write, clear-on-start and 128-bit flat output.

Test Plan:
- Zero-wait refill: req_addr=32'h0000_1008 -> haddr 1008,100C,1000,1004; htrans NONSEQ,SEQ,SEQ,SEQ; line_addr=32'h1000; line_done at T+6; data in the correct slots.
- Wait states: hready=0 for 2 cycles on beat 1 -> haddr/htrans held; same line_data as the zero-wait run; line_done delayed by 2.
- Aligned start: req_addr=32'h0000_2000 -> addresses 2000,2004,2008,200C; critical word in line_data[31:0].
- ERROR on beat 2 data -> htrans=IDLE the cycle after hresp=1/hready=0; line_done with line_err=1; req_ready=1 afterwards.
- rst asserted in the cycle after beat 1 data -> htrans=IDLE next edge; no line_done; a new request at 32'h3004 runs cleanly.
- REFILL_EARLY_RESTART_EN with req_addr=32'h100C -> word_idx sequence 3,0,1,2, each word_valid one cycle after its capture.

Source files
------------

// File: rtl/interface_pkg.sv
// Shared AHB-Lite encodings and refill-master types, common to the initiator and responder sides.
package interface_pkg;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2
    } burst_types_t;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } trans_types_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LAST,
        ST_ERR,
        ST_DONE
    } refill_states_t;

    localparam int         WRAP4_BEATS = 4;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    // Beat address inside a 16-byte line; idx is 2-bit so the wrap never carries into bit 4.
    function automatic logic [31:0] wrap4_addr(input logic [31:0] base, input logic [1:0] idx);
        return base | {28'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/refill_line_buffer.sv
// Four-word line store for a WRAP4 refill: indexed word write, clear at burst start, flat 128-bit view.
module refill_line_buffer
    import interface_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         wr_en,
    input  logic [1:0]   wr_idx,
    input  logic [31:0]  wr_data,
    output logic [127:0] line
);

    logic [31:0] words [WRAP4_BEATS];

    // NOTE: the word store is reset (not left as plain RAM) so line_data reads 0 out of reset,
    // and clearing at burst start keeps words from an earlier or cancelled burst out of this line.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < WRAP4_BEATS; i++) begin
                words[i] <= '0;
            end
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    assign line = {words[3], words[2], words[1], words[0]};

endmodule

// File: rtl/ahb_refill_master.sv
// AHB-Lite initiator issuing one critical-word-first WRAP4 read per I-cache miss.
// Define REFILL_EARLY_RESTART_EN to add the per-word word_valid/word_data/word_idx outputs.
module ahb_refill_master
    import interface_pkg::*;
#(
    parameter logic [31:0] WRAP4_BOUNDARY_MASK = 32'hFFFF_FFF0,
    parameter logic [3:0]  HPROT_VAL           = 4'b0010
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic [31:0]  req_addr,
    output logic         req_ready,
    output logic [31:0]  haddr,
    output logic [1:0]   htrans,
    output logic [2:0]   hburst,
    output logic [2:0]   hsize,
    output logic         hwrite,
    output logic [3:0]   hprot,
    input  logic [31:0]  hrdata,
    input  logic         hready,
    input  logic         hresp,
    output logic         line_done,
    output logic         line_err,
    output logic [127:0] line_data,
    output logic [31:0]  line_addr
`ifdef REFILL_EARLY_RESTART_EN
    ,
    output logic         word_valid,
    output logic [31:0]  word_data,
    output logic [1:0]   word_idx
`endif
);

    refill_states_t state;
    logic [31:0]    base;
    logic [1:0]     off;
    logic [1:0]     a_cnt;
    logic [1:0]     d_cnt;
    logic           data_pending;
    logic           capture;
    logic [1:0]     cap_idx;
    logic           start;

    assign hburst = BURST_WRAP4;
    assign hsize  = HSIZE_WORD;
    assign hwrite = 1'b0;
    assign hprot  = HPROT_VAL;

    // In ADDR a data phase is outstanding once the address counter has run ahead of the data counter.
    assign data_pending = ((state == ST_ADDR) && (a_cnt != d_cnt)) || (state == ST_LAST);
    assign capture      = data_pending && hready && !hresp;
    assign cap_idx      = off + d_cnt;
    assign start        = (state == ST_IDLE) && req_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            htrans    <= TRANS_IDLE;
            haddr     <= '0;
            req_ready <= 1'b1;
            base      <= '0;
            off       <= '0;
            a_cnt     <= '0;
            d_cnt     <= '0;
            line_done <= 1'b0;
            line_err  <= 1'b0;
            line_addr <= '0;
        end else begin
            line_done <= 1'b0;
            if (capture) begin
                d_cnt <= d_cnt + 2'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        base      <= req_addr & WRAP4_BOUNDARY_MASK;
                        off       <= req_addr[3:2];
                        a_cnt     <= '0;
                        d_cnt     <= '0;
                        haddr     <= req_addr & ~32'd3;
                        htrans    <= TRANS_NONSEQ;
                        req_ready <= 1'b0;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (hresp) begin
                        htrans <= TRANS_IDLE;
                        state  <= ST_ERR;
                    end else if (hready) begin
                        if (a_cnt == 2'd3) begin
                            htrans <= TRANS_IDLE;
                            state  <= ST_LAST;
                        end else begin
                            a_cnt  <= a_cnt + 2'd1;
                            haddr  <= wrap4_addr(base, off + a_cnt + 2'd1);
                            htrans <= TRANS_SEQ;
                        end
                    end
                end
                ST_LAST: begin
                    if (hresp) begin
                        state <= ST_ERR;
                    end else if (hready) begin
                        line_done <= 1'b1;
                        line_err  <= 1'b0;
                        line_addr <= base;
                        state     <= ST_DONE;
                    end
                end
                ST_ERR: begin
                    if (hready) begin
                        line_done <= 1'b1;
                        line_err  <= 1'b1;
                        line_addr <= base;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    refill_line_buffer u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .clear   (start),
        .wr_en   (capture),
        .wr_idx  (cap_idx),
        .wr_data (hrdata),
        .line    (line_data)
    );

`ifdef REFILL_EARLY_RESTART_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            word_valid <= 1'b0;
            word_data  <= '0;
            word_idx   <= '0;
        end else begin
            word_valid <= capture;
            if (capture) begin
                word_data <= hrdata;
                word_idx  <= cap_idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ahb_refill_master.sv
// Bench for ahb_refill_master: an AHB responder with wait/error injection and a line-level reference model.
module tb_ahb_refill_master;
    import interface_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         req_ready;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic [2:0]   hburst;
    logic [2:0]   hsize;
    logic         hwrite;
    logic [3:0]   hprot;
    logic [31:0]  hrdata;
    logic         hready;
    logic         hresp;
    logic         line_done;
    logic         line_err;
    logic [127:0] line_data;
    logic [31:0]  line_addr;
`ifdef REFILL_EARLY_RESTART_EN
    logic         word_valid;
    logic [31:0]  word_data;
    logic [1:0]   word_idx;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int wait_plan [4];
    int err_beat;
    int rst_beat;
    bit noise;

    always #5 clk = ~clk;

    ahb_refill_master dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .haddr     (haddr),
        .htrans    (htrans),
        .hburst    (hburst),
        .hsize     (hsize),
        .hwrite    (hwrite),
        .hprot     (hprot),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp),
        .line_done (line_done),
        .line_err  (line_err),
        .line_data (line_data),
        .line_addr (line_addr)
`ifdef REFILL_EARLY_RESTART_EN
        ,
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_idx   (word_idx)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Responder memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One refill: drive the request, act as the AHB responder, and compare against the line model.
    task automatic run_refill(input logic [31:0] addr, input string name);
        logic [31:0]  base;
        logic [31:0]  exp_addr [4];
        logic [127:0] exp_line;
        logic [31:0]  acc_addr [$];
        logic [1:0]   acc_trans [$];
        logic [31:0]  dp_addr, cur_addr, hold_addr, cap_data;
        logic [1:0]   cur_trans, hold_trans;
        int off, idx, cap_idx, beats_done, total_waits, err_stage, dp_beat, waits_left;
        bit dp_valid, hold_chk, cap_prev, done, err_checked, saw_done, is_err;

        base = addr & 32'hFFFF_FFF0;
        off  = int'(addr[3:2]);
        for (int n = 0; n < 4; n++) begin
            exp_addr[n] = base + 32'(((off + n) % 4) * 4);
        end
        exp_line    = '0;
        beats_done  = 0;
        total_waits = 0;
        err_stage   = 0;
        dp_beat     = 0;
        waits_left  = 0;
        cap_idx     = 0;
        cap_data    = '0;
        dp_addr     = '0;
        hold_addr   = '0;
        hold_trans  = '0;
        dp_valid    = 1'b0;
        hold_chk    = 1'b0;
        cap_prev    = 1'b0;
        done        = 1'b0;
        err_checked = 1'b0;
        is_err      = (err_beat >= 0);

        @(negedge clk);
        check({name, ": req_ready before request"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = addr;
        hready    = 1'b1;
        hresp     = 1'b0;
        @(negedge clk);
        if (noise) req_addr = $urandom;
        else       req_valid = 1'b0;

        for (int c = 1; c <= 80; c++) begin
            cur_addr  = haddr;
            cur_trans = htrans;
`ifdef REFILL_EARLY_RESTART_EN
            check({name, ": word_valid"}, word_valid, cap_prev);
            if (cap_prev) begin
                check({name, ": word_idx"}, word_idx, cap_idx);
                check({name, ": word_data"}, word_data, cap_data);
            end
`endif
            if (line_done) begin
                done = 1'b1;
                check({name, ": line_addr"}, line_addr, base);
                check({name, ": line_err"}, line_err, is_err);
                check({name, ": line_data"}, line_data, exp_line);
                check({name, ": req_ready during done"}, req_ready, 1'b0);
                check({name, ": accepted beats"}, acc_addr.size(), is_err ? err_beat + 1 : 4);
                for (int i = 0; i < acc_addr.size() && i < 4; i++) begin
                    check($sformatf("%s: haddr beat %0d", name, i), acc_addr[i], exp_addr[i]);
                    check($sformatf("%s: htrans beat %0d", name, i), acc_trans[i],
                          (i == 0) ? TRANS_NONSEQ : TRANS_SEQ);
                end
                if (!is_err) check({name, ": line_done latency"}, c, 6 + total_waits);
                req_valid = 1'b0;
                @(negedge clk);
                check({name, ": line_done one cycle"}, line_done, 1'b0);
                check({name, ": req_ready after done"}, req_ready, 1'b1);
                break;
            end
            if (hold_chk) begin
                check({name, ": haddr held in wait"}, haddr, hold_addr);
                check({name, ": htrans held in wait"}, htrans, hold_trans);
                hold_chk = 1'b0;
            end
            if (err_stage == 1 && !err_checked) begin
                check({name, ": htrans idle after error"}, htrans, TRANS_IDLE);
                err_checked = 1'b1;
            end
            if (rst_beat >= 0 && beats_done == rst_beat + 1) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check({name, ": htrans after reset"}, htrans, TRANS_IDLE);
                check({name, ": req_ready after reset"}, req_ready, 1'b1);
                check({name, ": line_data after reset"}, line_data, 128'd0);
                saw_done = line_done;
                repeat (8) begin
                    @(negedge clk);
                    if (line_done) saw_done = 1'b1;
                end
                check({name, ": no line_done after reset"}, saw_done, 1'b0);
                done = 1'b1;
                break;
            end

            hready = 1'b1;
            hresp  = 1'b0;
            hrdata = $urandom;
            if (dp_valid) begin
                if (dp_beat == err_beat) begin
                    hresp  = 1'b1;
                    hready = (err_stage >= 1);
                end else if (waits_left > 0) begin
                    hready = 1'b0;
                    waits_left--;
                    total_waits++;
                end else begin
                    hrdata = mem_word(dp_addr);
                end
            end

            @(posedge clk);
            cap_prev = 1'b0;
            if (dp_valid && hresp) err_stage++;
            if (!hready && !hresp && cur_trans != TRANS_IDLE) begin
                hold_chk   = 1'b1;
                hold_addr  = cur_addr;
                hold_trans = cur_trans;
            end
            if (hready) begin
                if (dp_valid && !hresp && dp_beat < 4) begin
                    idx = (off + dp_beat) % 4;
                    exp_line[idx*32 +: 32] = mem_word(exp_addr[dp_beat]);
                    cap_prev = 1'b1;
                    cap_idx  = idx;
                    cap_data = mem_word(exp_addr[dp_beat]);
                    beats_done++;
                end
                dp_valid = (cur_trans == TRANS_NONSEQ) || (cur_trans == TRANS_SEQ);
                if (dp_valid) begin
                    dp_beat = acc_addr.size();
                    dp_addr = cur_addr;
                    acc_addr.push_back(cur_addr);
                    acc_trans.push_back(cur_trans);
                    waits_left = (dp_beat < 4) ? wait_plan[dp_beat] : 0;
                end
            end
            @(negedge clk);
        end
        check({name, ": finished within cycle budget"}, done, 1'b1);
        req_valid = 1'b0;
        hready    = 1'b1;
        hresp     = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        hready    = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        err_beat  = -1;
        rst_beat  = -1;
        noise     = 1'b0;
        wait_plan = '{0, 0, 0, 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset htrans", htrans, TRANS_IDLE);
        check("reset haddr", haddr, 32'd0);
        check("reset req_ready", req_ready, 1'b1);
        check("reset line_done", line_done, 1'b0);
        check("reset line_err", line_err, 1'b0);
        check("reset line_data", line_data, 128'd0);
        check("reset line_addr", line_addr, 32'd0);
        check("hburst", hburst, BURST_WRAP4);
        check("hsize", hsize, 3'b010);
        check("hwrite", hwrite, 1'b0);
        check("hprot", hprot, 4'b0010);
        rst = 1'b0;

        run_refill(32'h0000_1008, "zero_wait");
        wait_plan = '{0, 2, 0, 0};
        run_refill(32'h0000_1008, "wait_beat1");
        wait_plan = '{0, 0, 0, 0};
        run_refill(32'h0000_2000, "aligned");
        err_beat = 2;
        run_refill(32'h0000_4008, "error_beat2");
        err_beat = -1;
        rst_beat = 1;
        run_refill(32'h0000_5008, "mid_reset");
        rst_beat = -1;
        run_refill(32'h0000_3004, "after_reset");
        run_refill(32'h0000_100C, "crit_word_3");

        for (int t = 0; t < 25; t++) begin
            for (int b = 0; b < 4; b++) begin
                wait_plan[b] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            err_beat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            noise    = ($urandom_range(0, 1) == 1);
            run_refill($urandom, $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
